// File: rtl/rr_index_arbiter.sv
// ----------------------------------------------------------------------------
// rr_index_arbiter
//
// Round-robin arbiter that turns a level request vector into a registered
// binary grant index with a valid/ready handshake. The index feeds a one-hot
// decoder directly, so it is held stable for as long as it is offered.
// Full throughput: a new index can be offered every cycle.
//
// Optional feature macro: ARB_LOCK_EN
//   defined   : lock_i on a handshake keeps the current winner (burst
//               ownership) while its request is still high.
//   undefined : lock_i is ignored, pure round-robin.
//
// Ports
//   clk_i          in   1        clock, rising edge
//   rst_ni         in   1        asynchronous active-low reset
//   req_i          in   NUM_REQ  level requests, bit i = requester i
//   lock_i         in   1        hold current winner (ARB_LOCK_EN only)
//   idx_valid_o    out  1        idx_o holds a granted requester
//   idx_ready_i    in   1        downstream accepts idx_o this cycle
//   idx_o          out  IDX_W    granted requester number (< NUM_REQ)
//   ptr_dbg_o      out  IDX_W    current round-robin priority pointer
//
// States
//   IDLE  | nothing offered, idx_valid_o = 0, idx_o holds last winner
//   OFFER | idx_o offered, idx_valid_o = 1, frozen until handshake
// ----------------------------------------------------------------------------
module rr_index_arbiter #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               lock_i,
    output logic               idx_valid_o,
    input  logic               idx_ready_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic [IDX_W-1:0]   ptr_dbg_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;

    logic [IDX_W-1:0]   ptr_upd;
    logic [IDX_W-1:0]   search_ptr;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               handshake;
    logic               lock_hold;

    // Pointer after accepting the current index: the winner becomes lowest
    // priority. Wraps at NUM_REQ, which need not be a power of two.
    assign ptr_upd = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    assign any_req   = |req_i;
    assign handshake = (state_q == OFFER) && idx_ready_i;

    // A single search serves both cases: from the live pointer when idle, and
    // from the pointer being written this cycle when a handshake completes,
    // so back-to-back grants already see the updated priority.
    assign search_ptr = (state_q == OFFER) ? ptr_upd : ptr_q;

`ifdef ARB_LOCK_EN
    assign lock_hold = lock_i && req_i[idx_q];
`else
    logic lock_unused;
    assign lock_unused = lock_i;
    assign lock_hold   = 1'b0;
`endif

    // Rotate the request vector so that search_ptr lands on bit 0, take the
    // lowest set bit, then add the pointer back modulo NUM_REQ.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_shift;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     rot_off;
    logic                 rot_found;
    logic [IDX_W:0]       win_sum;

    assign req_dbl   = {req_i, req_i};
    assign req_shift = req_dbl >> search_ptr;
    assign req_rot   = req_shift[NUM_REQ-1:0];

    always_comb begin
        rot_found = 1'b0;
        rot_off   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!rot_found && req_rot[j]) begin
                rot_found = 1'b1;
                rot_off   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        win_sum = {1'b0, search_ptr} + {1'b0, rot_off};
        if (win_sum >= NUM_REQ_W) begin
            win_sum = win_sum - NUM_REQ_W;
        end
        winner = win_sum[IDX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = winner;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Without a handshake the offer is frozen: no retraction,
                // even if the winner drops its request.
                if (handshake) begin
                    if (lock_hold) begin
                        idx_d = idx_q;
                    end else begin
                        ptr_d = ptr_upd;
                        if (any_req) begin
                            idx_d = winner;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign idx_valid_o = (state_q == OFFER);
    assign idx_o       = idx_q;
    assign ptr_dbg_o   = ptr_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_index_arbiter
//
// Directed-vector bench for rr_index_arbiter (NUM_REQ=16). Inputs change and
// outputs are sampled 1 ns after each rising edge. Expectations for the lock
// scenario follow whether ARB_LOCK_EN is defined for the build.
// ----------------------------------------------------------------------------
module tb_rr_index_arbiter;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    logic               clk_i;
    logic               rst_ni;
    logic [NUM_REQ-1:0] req_i;
    logic               lock_i;
    logic               idx_valid_o;
    logic               idx_ready_i;
    logic [IDX_W-1:0]   idx_o;
    logic [IDX_W-1:0]   ptr_dbg_o;

    int n_cmp;
    int n_err;

    rr_index_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .idx_valid_o (idx_valid_o),
        .idx_ready_i (idx_ready_i),
        .idx_o       (idx_o),
        .ptr_dbg_o   (ptr_dbg_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_offer(input string tag, input int exp_idx, input int exp_ptr);
        chk({tag, ".valid"}, 32'(idx_valid_o), 32'd1);
        chk({tag, ".idx"},   32'(idx_o),       32'(exp_idx));
        chk({tag, ".ptr"},   32'(ptr_dbg_o),   32'(exp_ptr));
    endtask

`ifdef ARB_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    initial begin
        int exp_i;
        n_cmp       = 0;
        n_err       = 0;
        rst_ni      = 1'b0;
        req_i       = 16'hFFFF;
        lock_i      = 1'b0;
        idx_ready_i = 1'b0;

        // Reset held with every requester active: nothing offered.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst.valid", 32'(idx_valid_o), 32'd0);
            chk("rst.ptr",   32'(ptr_dbg_o),   32'd0);
            chk("rst.idx",   32'(idx_o),       32'd0);
        end
        rst_ni = 1'b1;
        step();
        chk_offer("rel", 0, 0);

        // All requesting, ready constant: 1,2,...,15,0 with no bubble.
        idx_ready_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            exp_i = k % 16;
            step();
            chk_offer("ffff", exp_i, exp_i);
        end

        // Two requesters at the extremes: 15,0,15,0 and pointer wrap 15->0.
        req_i = 16'h8001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_offer("8001.a", 15, 1);
            step();
            chk_offer("8001.b", 0, 0);
        end

        // Offer of 4 stays frozen while ready low, even with req dropped.
        req_i = 16'h0010;
        step();
        chk_offer("hold.grant", 4, 1);
        idx_ready_i = 1'b0;
        req_i       = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_offer("hold", 4, 1);
        end
        idx_ready_i = 1'b1;
        step();
        chk("hs.valid", 32'(idx_valid_o), 32'd0);
        chk("hs.ptr",   32'(ptr_dbg_o),   32'd5);
        chk("hs.idx",   32'(idx_o),       32'd4);
        step();
        chk("idle_rdy.valid", 32'(idx_valid_o), 32'd0);
        chk("idle_rdy.ptr",   32'(ptr_dbg_o),   32'd5);

        // Reset asserted in the middle of an offer of 7.
        idx_ready_i = 1'b0;
        req_i       = 16'h0080;
        step();
        chk_offer("pre_rst", 7, 5);
        step();
        chk_offer("pre_rst.hold", 7, 5);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst.valid", 32'(idx_valid_o), 32'd0);
        chk("mid_rst.ptr",   32'(ptr_dbg_o),   32'd0);
        chk("mid_rst.idx",   32'(idx_o),       32'd0);
        req_i = 16'h0000;
        step();
        rst_ni = 1'b1;
        step();
        chk("post_rst.valid", 32'(idx_valid_o), 32'd0);

        // Lock scenario on requesters 1 and 2.
        req_i       = 16'h0006;
        lock_i      = 1'b1;
        idx_ready_i = 1'b1;
        step();
        chk_offer("lock.first", 1, 0);
        step();
        if (LOCK_BUILD) chk_offer("lock.1", 1, 0); else chk_offer("lock.1", 2, 2);
        step();
        if (LOCK_BUILD) chk_offer("lock.2", 1, 0); else chk_offer("lock.2", 1, 3);
        step();
        if (LOCK_BUILD) chk_offer("lock.3", 1, 0); else chk_offer("lock.3", 2, 2);
        lock_i = 1'b0;
        step();
        if (LOCK_BUILD) chk_offer("unlock", 2, 2); else chk_offer("unlock", 1, 3);
        // Lock with the current winner no longer requesting acts as no lock.
        lock_i = 1'b1;
        req_i  = 16'h0002;
        step();
        if (LOCK_BUILD) chk_offer("lock_noreq", 1, 3); else chk_offer("lock_noreq", 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
